// File: rtl/ahb_decoder_mux_p_pkg.sv
// Shared AHB-lite definitions for the parametrised decoder / response mux:
// bus widths, HTRANS/HRESP encodings, default-slave states and the legacy
// 7-slave DAHB/IAHB address map used as the default configuration.
package ahb_decoder_mux_p_pkg;

   localparam int AHB_ADDR_WIDTH = 32;
   localparam int AHB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   // Default-slave error sequencer states.
   typedef enum logic [1:0] {
      DS_OK   = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_e;

   // Legacy fabric: seven 256 MB windows selected by the top address nibble.
   localparam int LEGACY_NUM_SLAVES = 7;

   localparam logic [LEGACY_NUM_SLAVES*32-1:0] LEGACY_SLV_BASE = {
      32'h9000_0000,   // slave 6
      32'h8000_0000,   // slave 5
      32'h7000_0000,   // slave 4
      32'h6000_0000,   // slave 3
      32'h5000_0000,   // slave 2
      32'h4000_0000,   // slave 1
      32'h0000_0000    // slave 0
   };

   localparam logic [LEGACY_NUM_SLAVES*32-1:0] LEGACY_SLV_MASK = {
      32'hF000_0000,
      32'hF000_0000,
      32'hF000_0000,
      32'hF000_0000,
      32'hF000_0000,
      32'hF000_0000,
      32'hF000_0000
   };

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never select.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_decoder_mux_p_default_slave.sv
// Internal default slave: answers every unmapped transfer with the
// two-cycle AHB ERROR response (ready low, then ready high, both ERROR).
module ahb_default_slave
   import ahb_decoder_mux_p_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       unmapped,
   input  logic       HREADY_S,
   input  logic       sel_default,
   output logic       ready,
   output logic [1:0] resp
);

   ds_state_e  state_q;
   logic       ready_q;
   logic [1:0] resp_q;

   // Error sequencer with registered ready/resp, so nothing combinational
   // from the address phase reaches HREADY_S through this block.
   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values; blocking here would create order-dependent
   // simulation that no longer matches the synthesized flops.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= DS_OK;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else begin
         unique case (state_q)
            DS_OK: begin
               if (unmapped && HREADY_S) begin
                  state_q <= DS_ERR1;
                  ready_q <= 1'b0;
                  resp_q  <= HRESP_ERROR;
               end
            end
            DS_ERR1: begin
               // The data phase is always owned by us here; the guard only
               // recovers from an impossible owner change.
               if (sel_default) begin
                  state_q <= DS_ERR2;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_ERROR;
               end else begin
                  state_q <= DS_OK;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
            DS_ERR2: begin
               // Ready is high, so the next address phase is accepted now.
               if (unmapped && HREADY_S) begin
                  state_q <= DS_ERR1;
                  ready_q <= 1'b0;
                  resp_q  <= HRESP_ERROR;
               end else begin
                  state_q <= DS_OK;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
            default: begin
               state_q <= DS_OK;
               ready_q <= 1'b1;
               resp_q  <= HRESP_OKAY;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign resp  = resp_q;

endmodule

// File: rtl/ahb_decoder_mux_p.sv
// Parametrised AHB-lite address decoder and slave-response multiplexer
// with an internal error-returning default slave and a sticky log of the
// first unmapped address seen since software last cleared it.
module ahb_decoder_mux_p
   import ahb_decoder_mux_p_pkg::*;
#(
   parameter int                          NUM_SLAVES = LEGACY_NUM_SLAVES, // 1..16
   parameter logic [NUM_SLAVES*32-1:0]    SLV_BASE   = LEGACY_SLV_BASE,
   parameter logic [NUM_SLAVES*32-1:0]    SLV_MASK   = LEGACY_SLV_MASK
) (
   input  logic                                 HCLK,
   input  logic                                 HRESETn,
   input  logic [AHB_ADDR_WIDTH-1:0]            HADDR_M,
   input  logic [1:0]                           HTRANS_M,
   output logic [NUM_SLAVES-1:0]                HSEL_S,
   input  logic [NUM_SLAVES*AHB_DATA_WIDTH-1:0] HRDATA_IN,
   input  logic [NUM_SLAVES*2-1:0]              HRESP_IN,
   input  logic [NUM_SLAVES-1:0]                HREADYOUT_IN,
   output logic [AHB_DATA_WIDTH-1:0]            HRDATA_S,
   output logic [1:0]                           HRESP_S,
   output logic                                 HREADY_S,
   output logic                                 err_valid,
   output logic [AHB_ADDR_WIDTH-1:0]            err_addr,
   input  logic                                 err_clr
);

   localparam int DEF = NUM_SLAVES;   // dsel bit owned by the default slave
   localparam logic [NUM_SLAVES:0] DSEL_DEFAULT = {1'b1, {NUM_SLAVES{1'b0}}};

   logic                      trans;
   logic                      unmapped;
   logic [NUM_SLAVES-1:0]     match;

   logic [NUM_SLAVES:0]       dsel_q;
   logic [NUM_SLAVES:0]       dsel_d;

   logic                      ds_ready;
   logic [1:0]                ds_resp;

   logic                      err_accept;
   logic                      err_valid_q;
   logic [AHB_ADDR_WIDTH-1:0] err_addr_q;

   assign trans = htrans_active(HTRANS_M);

   // Per-slave address match, each region evaluated independently.
   // NOTE: every always_comb output gets a default before any condition;
   // a path that leaves a variable unassigned would infer a latch.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         match[i] = trans &&
                    ((HADDR_M & SLV_MASK[32*i +: 32]) ==
                     (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]));
      end
   end

   // Priority encode overlaps so the lowest index wins and HSEL_S is
   // one-hot or zero.
   always_comb begin
      logic found;
      HSEL_S = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (match[i] && !found) begin
            HSEL_S[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign unmapped = trans && (match == '0);

   // Next data-phase owner: loads only on an accepted address phase.
   always_comb begin
      dsel_d = dsel_q;
      if (HREADY_S) begin
         if (HSEL_S != '0) begin
            dsel_d = {1'b0, HSEL_S};
         end else begin
            dsel_d = DSEL_DEFAULT;
         end
      end
   end

   // Data-phase owner register, parked on the default slave out of reset.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_q <= DSEL_DEFAULT;
      end else begin
         dsel_q <= dsel_d;
      end
   end

   ahb_default_slave u_default_slave (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .unmapped    (unmapped),
      .HREADY_S    (HREADY_S),
      .sel_default (dsel_q[DEF]),
      .ready       (ds_ready),
      .resp        (ds_resp)
   );

   // Response mux driven purely by the registered owner, so HREADY_S has
   // no combinational path back into the decode.
   always_comb begin
      HRDATA_S = '0;
      HRESP_S  = HRESP_OKAY;
      HREADY_S = 1'b1;
      if (dsel_q[DEF]) begin
         HRESP_S  = ds_resp;
         HREADY_S = ds_ready;
      end else begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q[i]) begin
               HRDATA_S = HRDATA_IN[AHB_DATA_WIDTH*i +: AHB_DATA_WIDTH];
               HRESP_S  = HRESP_IN[2*i +: 2];
               HREADY_S = HREADYOUT_IN[i];
            end
         end
      end
   end

   assign err_accept = unmapped && HREADY_S;

   // Sticky error log: first unmapped address is kept until cleared; a new
   // error in the clearing cycle replaces the old entry.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
      end else if (err_accept && (!err_valid_q || err_clr)) begin
         err_valid_q <= 1'b1;
         err_addr_q  <= HADDR_M;
      end else if (err_clr) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahb_decoder_mux_p.sv
// Bench for ahb_decoder_mux_p: a legacy-map instance and a 3-slave instance
// with overlapping regions share one stimulus stream. A transaction-level
// model (owner index, remaining error cycles, error log) predicts every
// output on every cycle; directed phases pin the model with literals.
module tb_ahb_decoder_mux_p;

   localparam int N7 = 7;
   localparam int N3 = 3;
   localparam int DW = 32;

   localparam logic [31:0] MBASE [2][7] = '{
      '{32'h0000_0000, 32'h4000_0000, 32'h5000_0000, 32'h6000_0000,
        32'h7000_0000, 32'h8000_0000, 32'h9000_0000},
      '{32'h0000_1000, 32'h0000_0000, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h0}
   };
   localparam logic [31:0] MMASK [2][7] = '{
      '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
      '{32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000, 32'h0, 32'h0, 32'h0, 32'h0}
   };
   localparam int MN [2] = '{N7, N3};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]      haddr;
   logic [1:0]       htrans;
   logic             err_clr;
   logic [N7*DW-1:0] hrdata_in;
   logic [N7*2-1:0]  hresp_in;
   logic [N7-1:0]    hrdyout;

   logic [N7-1:0] hsel7;
   logic [31:0]   hrdata7, ea7;
   logic [1:0]    hresp7;
   logic          hready7, ev7;

   logic [N3-1:0] hsel3;
   logic [31:0]   hrdata3, ea3;
   logic [1:0]    hresp3;
   logic          hready3, ev3;

   int checks = 0;
   int errors = 0;

   ahb_decoder_mux_p u_dut7 (
      .HCLK         (clk),
      .HRESETn      (rst_n),
      .HADDR_M      (haddr),
      .HTRANS_M     (htrans),
      .HSEL_S       (hsel7),
      .HRDATA_IN    (hrdata_in),
      .HRESP_IN     (hresp_in),
      .HREADYOUT_IN (hrdyout),
      .HRDATA_S     (hrdata7),
      .HRESP_S      (hresp7),
      .HREADY_S     (hready7),
      .err_valid    (ev7),
      .err_addr     (ea7),
      .err_clr      (err_clr)
   );

   ahb_decoder_mux_p #(
      .NUM_SLAVES (N3),
      .SLV_BASE   ({32'h1000_0000, 32'h0000_0000, 32'h0000_1000}),
      .SLV_MASK   ({32'hF000_0000, 32'hF000_0000, 32'hFFFF_F000})
   ) u_dut3 (
      .HCLK         (clk),
      .HRESETn      (rst_n),
      .HADDR_M      (haddr),
      .HTRANS_M     (htrans),
      .HSEL_S       (hsel3),
      .HRDATA_IN    (hrdata_in[N3*DW-1:0]),
      .HRESP_IN     (hresp_in[N3*2-1:0]),
      .HREADYOUT_IN (hrdyout[N3-1:0]),
      .HRDATA_S     (hrdata3),
      .HRESP_S      (hresp3),
      .HREADY_S     (hready3),
      .err_valid    (ev3),
      .err_addr     (ea3),
      .err_clr      (err_clr)
   );

   // ---------------- behavioural model ----------------
   // owner: slave index owning the data phase, -1 for the default slave.
   // ecnt : error data-phase cycles still to come (2 = ready-low cycle next).
   int          m_owner [2] = '{-1, -1};
   int          m_ecnt  [2] = '{0, 0};
   bit          m_ev    [2] = '{1'b0, 1'b0};
   logic [31:0] m_ea    [2] = '{32'h0, 32'h0};

   // -2: no transfer, -1: unmapped, else lowest matching slave.
   function automatic int decode(int d, logic [31:0] a, logic [1:0] t);
      if (t == 2'b00 || t == 2'b01) return -2;
      for (int i = 0; i < MN[d]; i++)
         if (((a ^ MBASE[d][i]) & MMASK[d][i]) == 32'h0) return i;
      return -1;
   endfunction

   function automatic logic exp_ready(int d);
      if (m_owner[d] >= 0) return hrdyout[m_owner[d]];
      return m_ecnt[d] != 2;
   endfunction

   function automatic logic [1:0] exp_resp(int d);
      if (m_owner[d] >= 0) return hresp_in[2*m_owner[d] +: 2];
      return (m_ecnt[d] == 0) ? 2'b00 : 2'b01;
   endfunction

   function automatic logic [31:0] exp_rdata(int d);
      if (m_owner[d] >= 0) return hrdata_in[DW*m_owner[d] +: DW];
      return 32'h0;
   endfunction

   function automatic logic [6:0] exp_hsel(int d);
      int k;
      k = decode(d, haddr, htrans);
      return (k >= 0) ? 7'(1 << k) : 7'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_owner[d] <= -1;
            m_ecnt[d]  <= 0;
            m_ev[d]    <= 1'b0;
            m_ea[d]    <= 32'h0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            automatic int k = decode(d, haddr, htrans);
            if (exp_ready(d)) begin
               m_owner[d] <= (k >= 0) ? k : -1;
               m_ecnt[d]  <= (k == -1) ? 2 : 0;
               if (k == -1 && (!m_ev[d] || err_clr)) begin
                  m_ev[d] <= 1'b1;
                  m_ea[d] <= haddr;
               end else if (err_clr) begin
                  m_ev[d] <= 1'b0;
                  m_ea[d] <= 32'h0;
               end
            end else begin
               if (m_ecnt[d] == 2) m_ecnt[d] <= 1;
               if (err_clr) begin
                  m_ev[d] <= 1'b0;
                  m_ea[d] <= 32'h0;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("m.hsel7",   64'(hsel7),   64'(exp_hsel(0)));
      check("m.hrdata7", 64'(hrdata7), 64'(exp_rdata(0)));
      check("m.hresp7",  64'(hresp7),  64'(exp_resp(0)));
      check("m.hready7", 64'(hready7), 64'(exp_ready(0)));
      check("m.ev7",     64'(ev7),     64'(m_ev[0]));
      check("m.ea7",     64'(ea7),     64'(m_ea[0]));
      check("m.hsel3",   64'(hsel3),   64'(exp_hsel(1)));
      check("m.hrdata3", 64'(hrdata3), 64'(exp_rdata(1)));
      check("m.hresp3",  64'(hresp3),  64'(exp_resp(1)));
      check("m.hready3", 64'(hready3), 64'(exp_ready(1)));
      check("m.ev3",     64'(ev3),     64'(m_ev[1]));
      check("m.ea3",     64'(ea3),     64'(m_ea[1]));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      htrans  = 2'b00;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
         1:       return $urandom & 32'h0FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      haddr     = 32'h0;
      htrans    = 2'b00;
      err_clr   = 1'b0;
      hrdyout   = '1;
      hresp_in  = '0;
      for (int i = 0; i < N7; i++) hrdata_in[DW*i +: DW] = 32'h1111_1111 * (i + 1);
      hrdata_in[DW*4 +: DW] = 32'hDEAD_BEEF;

      // Reset state
      @(negedge clk);
      check("rst.hready7", 64'(hready7), 64'h1);
      check("rst.hresp7",  64'(hresp7),  64'h0);
      check("rst.hrdata7", 64'(hrdata7), 64'h0);
      check("rst.ev7",     64'(ev7),     64'h0);
      check("rst.ea7",     64'(ea7),     64'h0);
      #1 rst_n = 1'b1;

      // Legacy read from slave 4
      step();
      haddr = 32'h7000_0010; htrans = 2'b10;
      @(negedge clk);
      check("rd.hsel7", 64'(hsel7), 64'h10);
      step();
      htrans = 2'b00;
      @(negedge clk);
      check("rd.hrdata7", 64'(hrdata7), 64'hDEAD_BEEF);
      check("rd.hresp7",  64'(hresp7),  64'h0);
      check("rd.hready7", 64'(hready7), 64'h1);
      step();
      clear_log();

      // Single unmapped access
      haddr = 32'h2000_0004; htrans = 2'b10;
      @(negedge clk);
      check("um.hsel7", 64'(hsel7), 64'h0);
      check("um.hsel3", 64'(hsel3), 64'h0);
      step();
      htrans = 2'b00;
      @(negedge clk);
      check("um.err1.hready3", 64'(hready3), 64'h0);
      check("um.err1.hresp3",  64'(hresp3),  64'h1);
      check("um.err1.hready7", 64'(hready7), 64'h0);
      step();
      @(negedge clk);
      check("um.err2.hready3", 64'(hready3), 64'h1);
      check("um.err2.hresp3",  64'(hresp3),  64'h1);
      check("um.ev3",          64'(ev3),     64'h1);
      check("um.ea3",          64'(ea3),     64'h2000_0004);
      check("um.ea7",          64'(ea7),     64'h2000_0004);
      step();
      @(negedge clk);
      check("um.ok.hresp3", 64'(hresp3), 64'h0);
      clear_log();
      @(negedge clk);
      check("clr.ev3", 64'(ev3), 64'h0);

      // Back-to-back unmapped
      haddr = 32'h2000_0004; htrans = 2'b10;
      step();
      haddr = 32'h3000_0000;
      @(negedge clk);
      check("b2b.a.err1", 64'(hready7), 64'h0);
      step();
      @(negedge clk);
      check("b2b.a.err2.rdy",  64'(hready7), 64'h1);
      check("b2b.a.err2.resp", 64'(hresp7),  64'h1);
      step();
      htrans = 2'b00;
      @(negedge clk);
      check("b2b.b.err1.rdy",  64'(hready7), 64'h0);
      check("b2b.b.err1.resp", 64'(hresp7),  64'h1);
      step();
      @(negedge clk);
      check("b2b.b.err2.rdy", 64'(hready7), 64'h1);
      check("b2b.ea7",        64'(ea7),     64'h2000_0004);
      check("b2b.ea3",        64'(ea3),     64'h2000_0004);
      step();
      clear_log();
      @(negedge clk);
      check("b2b.clr.ev7", 64'(ev7), 64'h0);
      check("b2b.clr.ea7", 64'(ea7), 64'h0);

      // Slave 1 with three wait states; master moves HADDR meanwhile
      hrdata_in[DW*1 +: DW] = 32'h1234_5678;
      haddr = 32'h4000_0000; htrans = 2'b10;
      step();
      hrdyout[1] = 1'b0;
      haddr = 32'h7000_0010;
      @(negedge clk);
      check("ws.hsel7",  64'(hsel7),   64'h10);
      check("ws.w1",     64'(hready7), 64'h0);
      step();
      @(negedge clk);
      check("ws.w2", 64'(hready7), 64'h0);
      step();
      @(negedge clk);
      check("ws.w3", 64'(hready7), 64'h0);
      step();
      hrdyout[1] = 1'b1;
      @(negedge clk);
      check("ws.done.rdy",  64'(hready7), 64'h1);
      check("ws.done.data", 64'(hrdata7), 64'h1234_5678);
      step();
      htrans = 2'b00;
      @(negedge clk);
      check("ws.next.data", 64'(hrdata7), 64'hDEAD_BEEF);
      step();
      clear_log();

      // IDLE and BUSY to a mapped address
      haddr = 32'h4000_0000; htrans = 2'b00;
      @(negedge clk);
      check("idle.hsel7", 64'(hsel7), 64'h0);
      step();
      htrans = 2'b01;
      @(negedge clk);
      check("busy.hsel7",   64'(hsel7),   64'h0);
      check("busy.hready7", 64'(hready7), 64'h1);
      step();
      htrans = 2'b00;
      @(negedge clk);
      check("busy.hresp7", 64'(hresp7), 64'h0);
      check("busy.ev7",    64'(ev7),    64'h0);
      check("busy.ev3",    64'(ev3),    64'h0);

      // Reset asserted during the ready-low error cycle
      step();
      haddr = 32'h2000_0004; htrans = 2'b10;
      step();
      htrans = 2'b00;
      #1;
      check("mr.err1", 64'(hready7), 64'h0);
      rst_n = 1'b0;
      #1;
      check("mr.hready7", 64'(hready7), 64'h1);
      check("mr.hresp7",  64'(hresp7),  64'h0);
      check("mr.ev7",     64'(ev7),     64'h0);
      check("mr.hready3", 64'(hready3), 64'h1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      @(negedge clk);
      check("mr.after.rdy",  64'(hready7), 64'h1);
      check("mr.after.resp", 64'(hresp7),  64'h0);

      // Randomised traffic, checked every cycle by the model
      for (int n = 0; n < 3000; n++) begin
         step();
         haddr   = rand_addr();
         htrans  = 2'($urandom_range(0, 3));
         err_clr = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < N7; i++) begin
            hrdata_in[DW*i +: DW] = $urandom;
            hresp_in[2*i +: 2]    = 2'($urandom_range(0, 3));
            hrdyout[i]            = ($urandom_range(0, 3) != 0);
         end
      end
      step();
      htrans  = 2'b00;
      err_clr = 1'b0;
      hrdyout = '1;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
